// File: rtl/ddr_axi_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) between the ddr_axi_wr master and a
// DDR controller slave port. Signal names drop the m_axi_ prefix; the
// instance name carries it at the point of use.
interface ddr_axi_wr_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 29
);

  // Write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  // Write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/ddr_axi_wr.sv
// ddr_axi_wr: AXI4 write master that streams a first-word-fall-through FIFO
// into a sequence of equal-length INCR bursts. One command describes the
// start address, the beats per burst and the number of bursts. Bursts are
// strictly serialised: the next address phase starts only after the write
// response of the current burst, so at most one burst is ever outstanding.
module ddr_axi_wr #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 29,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int NUM_BURST_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,

  // Command side
  input  logic                       wr_start,
  input  logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
  input  logic [NUM_BURST_WIDTH-1:0] wr_num_burst,
  input  logic [ADDR_WIDTH-1:0]      wr_start_addr,
  output logic                       wr_ready,
  output logic                       wr_done,
  output logic                       wr_err,

  // Write FIFO (first-word-fall-through)
  output logic                       wr_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      wr_fifo_rd_data,
  input  logic                       wr_fifo_empty,

  // AXI4 write channels
  ddr_axi_wr_if.master               m_axi
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int SIZE_LOG2      = $clog2(BYTES_PER_BEAT);
  localparam int STEP_W         = BURST_LEN_WIDTH + SIZE_LOG2 + 1;

  localparam logic [2:0] AXI_SIZE  = 3'(SIZE_LOG2);
  localparam logic [1:0] AXI_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // AXI awlen is fixed at 8 bits; the command field may be narrower or wider.
  function automatic logic [7:0] to_awlen(input logic [BURST_LEN_WIDTH-1:0] len);
    return 8'(len);
  endfunction

  // Byte distance between consecutive burst start addresses:
  // (len + 1) beats of DATA_WIDTH/8 bytes, wrapped to the address width.
  function automatic logic [ADDR_WIDTH-1:0] burst_bytes(input logic [BURST_LEN_WIDTH-1:0] len);
    logic [STEP_W-1:0] beats;
    beats = STEP_W'(len) + STEP_W'(1'b1);
    return ADDR_WIDTH'(beats << SIZE_LOG2);
  endfunction

  state_t                     state_r;
  state_t                     state_s;
  logic [BURST_LEN_WIDTH-1:0] len_r;
  logic [BURST_LEN_WIDTH-1:0] beat_r;
  logic [NUM_BURST_WIDTH-1:0] remain_r;
  logic [ADDR_WIDTH-1:0]      addr_r;
  logic                       err_r;

  logic                       wvalid_s;
  logic                       aw_hs_s;
  logic                       w_hs_s;
  logic                       b_hs_s;
  logic                       last_beat_s;
  logic                       more_bursts_s;

  // Handshake and burst-position decode shared by the FSM and the datapath
  always_comb begin
    wvalid_s      = (state_r == ST_W) && !wr_fifo_empty;
    aw_hs_s       = (state_r == ST_AW) && m_axi.awready;
    w_hs_s        = wvalid_s && m_axi.wready;
    b_hs_s        = (state_r == ST_B) && m_axi.bvalid;
    last_beat_s   = (beat_r == len_r);
    more_bursts_s = (remain_r != NUM_BURST_WIDTH'(1'b1));
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_start) begin
          if (wr_num_burst == {NUM_BURST_WIDTH{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_AW;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_AW: begin
        if (aw_hs_s) begin
          state_s = ST_W;
        end else begin
          state_s = ST_AW;
        end
      end
      ST_W: begin
        if (w_hs_s && last_beat_s) begin
          state_s = ST_B;
        end else begin
          state_s = ST_W;
        end
      end
      ST_B: begin
        if (b_hs_s) begin
          if (more_bursts_s) begin
            state_s = ST_AW;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_B;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Command latch, beat counter, burst address and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r    <= {BURST_LEN_WIDTH{1'b0}};
      beat_r   <= {BURST_LEN_WIDTH{1'b0}};
      remain_r <= {NUM_BURST_WIDTH{1'b0}};
      addr_r   <= {ADDR_WIDTH{1'b0}};
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_start) begin
            len_r    <= wr_burst_len;
            remain_r <= wr_num_burst;
            addr_r   <= wr_start_addr;
            beat_r   <= {BURST_LEN_WIDTH{1'b0}};
            err_r    <= 1'b0;
          end
        end
        ST_AW: begin
          // Every burst starts counting beats from zero.
          beat_r <= {BURST_LEN_WIDTH{1'b0}};
        end
        ST_W: begin
          // Only a completed handshake advances; empty FIFO or wready=0 hold.
          if (w_hs_s) begin
            if (last_beat_s) begin
              beat_r <= {BURST_LEN_WIDTH{1'b0}};
            end else begin
              beat_r <= beat_r + BURST_LEN_WIDTH'(1'b1);
            end
          end
        end
        ST_B: begin
          if (b_hs_s) begin
            if (m_axi.bresp != RESP_OKAY) begin
              err_r <= 1'b1;
            end
            remain_r <= remain_r - NUM_BURST_WIDTH'(1'b1);
            // Address only moves when another burst follows, so awaddr keeps
            // showing the last burst address once the command has finished.
            if (more_bursts_s) begin
              addr_r <= addr_r + burst_bytes(len_r);
            end
          end
        end
        ST_DONE: begin
          beat_r <= {BURST_LEN_WIDTH{1'b0}};
        end
        default: begin
          beat_r <= {BURST_LEN_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Output decode: every output is a function of flops, except the W-channel
  // valid/pop which must follow the FIFO flag and the slave ready directly
  always_comb begin
    wr_ready      = (state_r == ST_IDLE);
    wr_done       = (state_r == ST_DONE);
    wr_err        = err_r;
    wr_fifo_rd_en = w_hs_s;

    m_axi.awaddr  = addr_r;
    m_axi.awlen   = to_awlen(len_r);
    m_axi.awsize  = AXI_SIZE;
    m_axi.awburst = AXI_INCR;
    m_axi.awvalid = (state_r == ST_AW);

    m_axi.wdata   = wr_fifo_rd_data;
    m_axi.wstrb   = {BYTES_PER_BEAT{1'b1}};
    m_axi.wvalid  = wvalid_s;
    m_axi.wlast   = (state_r == ST_W) && last_beat_s;

    m_axi.bready  = (state_r == ST_B);
  end

endmodule

// File: tb/tb_ddr_axi_wr.sv
// Self-checking bench for ddr_axi_wr. A transaction-level model predicts,
// from handshake counts alone, which channel must be active each cycle, the
// address of every burst, the data order and where wlast falls. Directed
// scenarios drive the FIFO and the AXI slave side and pin the model with
// hand-computed literals.
module tb_ddr_axi_wr;

  localparam int DW = 64;
  localparam int AW = 29;

  logic          clk;
  logic          rst;
  logic          wr_start;
  logic [7:0]    wr_burst_len;
  logic [7:0]    wr_num_burst;
  logic [AW-1:0] wr_start_addr;
  logic          wr_ready;
  logic          wr_done;
  logic          wr_err;
  logic          wr_fifo_rd_en;
  logic [DW-1:0] wr_fifo_rd_data;
  logic          wr_fifo_empty;

  ddr_axi_wr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

  ddr_axi_wr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN_WIDTH(8), .NUM_BURST_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_start(wr_start), .wr_burst_len(wr_burst_len), .wr_num_burst(wr_num_burst),
    .wr_start_addr(wr_start_addr), .wr_ready(wr_ready), .wr_done(wr_done),
    .wr_err(wr_err), .wr_fifo_rd_en(wr_fifo_rd_en), .wr_fifo_rd_data(wr_fifo_rd_data),
    .wr_fifo_empty(wr_fifo_empty), .m_axi(axi)
  );

  int checks = 0;
  int errors = 0;

  // Command seen by the model (independent of what is on the ports)
  int      cmd_len;
  int      cmd_num;
  longint  cmd_addr;

  // Model state
  bit      busy, done_due, m_err;
  int      aw_n, b_n, beats, cyc_n, start_cyc, done_cyc;
  logic [63:0] exp_data[$];

  // Bench FIFO and slave controls
  logic [63:0] fifo_q[$];
  bit          pop_req;
  bit          ready_pattern;
  logic [1:0]  bresp_tbl[4];
  int          drv_cyc = 0;
  logic [15:0] pat = 16'b1011_0010_1101_0110;

  // Logs for literal expectations
  logic [63:0] aw_log[$];
  logic [63:0] wlog[$];
  logic [63:0] wlast_log[$];
  int          rd_cnt, whs_cnt, done_cnt;
  bit          awv_seen, wv_seen, err_at_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] word(input int tag, input int k);
    return 64'hD000_0000_0000_0000 | (64'(tag) << 48) | 64'(k);
  endfunction

  function automatic logic [63:0] qget(input logic [63:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    else return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave / FIFO driver: updates inputs shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (pop_req) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_req = 1'b0;
    end
    wr_fifo_empty   = (fifo_q.size() == 0);
    wr_fifo_rd_data = (fifo_q.size() == 0) ? 64'h0 : fifo_q[0];
    axi.wready      = ready_pattern ? pat[drv_cyc % 16] : 1'b1;
    axi.awready     = ready_pattern ? pat[(drv_cyc + 5) % 16] : 1'b1;
    axi.bvalid      = 1'b1;
    axi.bresp       = (b_n < 4) ? bresp_tbl[b_n] : 2'b00;
    drv_cyc++;
  end

  // Model + compare: checks outputs mid-cycle, then applies this cycle's handshakes
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0; done_due = 1'b0; m_err = 1'b0;
      aw_n = 0; b_n = 0; beats = 0; pop_req = 1'b0;
    end else begin
      int  bpb;
      bit  e_aw, e_wph, e_b, e_wv;
      logic [63:0] e_addr;
      bpb   = cmd_len + 1;
      e_aw  = busy && (aw_n == b_n) && (b_n < cmd_num);
      e_wph = busy && (aw_n == b_n + 1) && (beats < aw_n * bpb);
      e_b   = busy && (aw_n == b_n + 1) && (beats == aw_n * bpb);
      e_wv  = e_wph && !wr_fifo_empty;
      e_addr = (64'(cmd_addr) + 64'(aw_n) * 64'(bpb) * 64'd8) & 64'h1FFF_FFFF;

      chk("wr_ready", wr_ready, !busy);
      chk("awvalid", axi.awvalid, e_aw);
      chk("wvalid", axi.wvalid, e_wv);
      chk("rd_en", wr_fifo_rd_en, e_wv && axi.wready);
      chk("bready", axi.bready, e_b);
      chk("wr_done", wr_done, done_due);
      chk("wr_err", wr_err, m_err);
      chk("awsize", axi.awsize, 3'd3);
      chk("awburst", axi.awburst, 2'b01);
      chk("wstrb", axi.wstrb, 8'hFF);
      if (e_aw) begin
        chk("awaddr", axi.awaddr, e_addr);
        chk("awlen", axi.awlen, 64'(cmd_len) & 64'hFF);
      end
      if (e_wv) begin
        chk("wdata", axi.wdata, qget(exp_data, 0));
        chk("wlast", axi.wlast, (beats - b_n * bpb) == cmd_len);
      end

      awv_seen |= axi.awvalid;
      wv_seen  |= axi.wvalid;
      if (wr_fifo_rd_en) begin rd_cnt++; pop_req = 1'b1; end
      if (axi.awvalid && axi.awready) begin
        aw_log.push_back(64'(axi.awaddr));
        aw_n++;
      end
      if (axi.wvalid && axi.wready) begin
        wlog.push_back(axi.wdata);
        if (axi.wlast) wlast_log.push_back(64'(beats));
        if (exp_data.size() > 0) void'(exp_data.pop_front());
        beats++;
        whs_cnt++;
      end
      if (axi.bready && axi.bvalid) begin
        if (axi.bresp != 2'b00) m_err = 1'b1;
        b_n++;
        if (b_n == cmd_num) done_due = 1'b1;
      end
      if (wr_done) begin done_cnt++; done_cyc = cyc_n; end
      if (e_b == 1'b0 && done_due && !(axi.bready && axi.bvalid)) begin
        err_at_done = wr_err;
        done_due = 1'b0;
        busy = 1'b0;
      end
      if (wr_start && !busy) begin
        busy = 1'b1; m_err = 1'b0;
        aw_n = 0; b_n = 0; beats = 0;
        done_due = (cmd_num == 0);
        start_cyc = cyc_n;
      end
      cyc_n++;
    end
  end

  task automatic start_cmd(input int len, input int num, input longint addr,
                           input int nwords, input int tag);
    aw_log.delete(); wlog.delete(); wlast_log.delete();
    rd_cnt = 0; whs_cnt = 0; awv_seen = 1'b0; wv_seen = 1'b0;
    cmd_len = len; cmd_num = num; cmd_addr = addr;
    exp_data.delete();
    for (int k = 0; k < (len + 1) * num; k++) exp_data.push_back(word(tag, k));
    @(posedge clk); #1;
    for (int k = 0; k < nwords; k++) fifo_q.push_back(word(tag, k));
    wr_burst_len = 8'(len); wr_num_burst = 8'(num); wr_start_addr = AW'(addr);
    wr_start = 1'b1;
    @(posedge clk); #1;
    wr_start = 1'b0;
  endtask

  task automatic push_words(input int tag, input int from, input int to);
    @(posedge clk); #1;
    for (int k = from; k < to; k++) fifo_q.push_back(word(tag, k));
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 400) begin @(negedge clk); #1; n++; end
    chk({name, " done seen"}, done_cnt != d0, 1'b1);
    repeat (3) begin @(negedge clk); #1; end
    chk({name, " single done"}, 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic wait_beats(input int n);
    int g;
    g = 0;
    while (whs_cnt < n && g < 300) begin @(negedge clk); #1; g++; end
    chk("beats reached", whs_cnt >= n, 1'b1);
  endtask

  initial begin
    int stall_ok;
    int d0;
    rst = 1'b0; wr_start = 1'b0; wr_burst_len = 8'd0; wr_num_burst = 8'd0;
    wr_start_addr = '0; wr_fifo_empty = 1'b1; wr_fifo_rd_data = 64'h0;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1; axi.bresp = 2'b00;
    ready_pattern = 1'b0;
    for (int i = 0; i < 4; i++) bresp_tbl[i] = 2'b00;
    cmd_len = 0; cmd_num = 0; cmd_addr = 0;
    done_cnt = 0; cyc_n = 0;

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst wr_ready", wr_ready, 1'b1);
    chk("rst wr_done", wr_done, 1'b0);
    chk("rst wr_err", wr_err, 1'b0);
    chk("rst awvalid", axi.awvalid, 1'b0);
    chk("rst wvalid", axi.wvalid, 1'b0);
    chk("rst wlast", axi.wlast, 1'b0);
    chk("rst bready", axi.bready, 1'b0);
    chk("rst rd_en", wr_fifo_rd_en, 1'b0);
    chk("rst awaddr", axi.awaddr, 0);
    chk("rst awlen", axi.awlen, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Two bursts of four beats, everything ready
    start_cmd(3, 2, 64'h100, 8, 1);
    wait_done("basic");
    chk("basic aw0", qget(aw_log, 0), 64'h100);
    chk("basic aw1", qget(aw_log, 1), 64'h120);
    chk("basic aw count", 64'(aw_log.size()), 2);
    chk("basic wlast beat4", qget(wlast_log, 0), 3);
    chk("basic wlast beat8", qget(wlast_log, 1), 7);
    chk("basic rd_en count", 64'(rd_cnt), 8);
    chk("basic err", err_at_done, 1'b0);

    // FIFO runs dry after beat 2 for five cycles
    start_cmd(3, 2, 64'h100, 2, 2);
    wait_beats(2);
    stall_ok = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (!axi.wvalid && !wr_fifo_rd_en) stall_ok++;
    end
    push_words(2, 2, 8);
    wait_done("stall");
    chk("stall cycles idle", 64'(stall_ok), 5);
    chk("stall beat3 data", qget(wlog, 2), 64'hD002_0000_0000_0002);
    chk("stall wlast beat4", qget(wlast_log, 0), 3);
    chk("stall wlast beat8", qget(wlast_log, 1), 7);

    // Irregular awready/wready, address wrap, ignored mid-command start
    ready_pattern = 1'b1;
    start_cmd(3, 2, 64'h1FFF_FFF0, 8, 3);
    repeat (3) @(posedge clk);
    #1 wr_start = 1'b1; wr_num_burst = 8'd5; wr_start_addr = AW'(64'h999);
    @(posedge clk); #1 wr_start = 1'b0;
    wait_done("backpressure");
    ready_pattern = 1'b0;
    chk("bp aw1 wrapped", qget(aw_log, 1), 64'h10);
    chk("bp rd_en count", 64'(rd_cnt), 8);
    chk("bp handshakes", 64'(whs_cnt), 8);
    chk("bp last word", qget(wlog, 7), 64'hD003_0000_0000_0007);

    // SLVERR on the second burst, sticky until the next command
    bresp_tbl[1] = 2'b10;
    start_cmd(1, 2, 64'h200, 4, 4);
    wait_done("slverr");
    chk("slverr at done", err_at_done, 1'b1);
    repeat (3) @(negedge clk);
    #1 chk("slverr held", wr_err, 1'b1);
    bresp_tbl[1] = 2'b00;

    // Zero bursts: immediate completion, no AXI traffic, error cleared
    start_cmd(0, 0, 64'h300, 0, 5);
    wait_done("zero");
    chk("zero done latency", 64'(done_cyc - start_cyc), 1);
    chk("zero no awvalid", awv_seen, 1'b0);
    chk("zero no wvalid", wv_seen, 1'b0);
    chk("zero err cleared", err_at_done, 1'b0);

    // Reset in the middle of the data phase
    start_cmd(7, 2, 64'h400, 16, 6);
    wait_beats(3);
    #1 rst = 1'b1;
    #1;
    chk("midrst wvalid", axi.wvalid, 1'b0);
    chk("midrst awvalid", axi.awvalid, 1'b0);
    chk("midrst bready", axi.bready, 1'b0);
    chk("midrst rd_en", wr_fifo_rd_en, 1'b0);
    chk("midrst wr_ready", wr_ready, 1'b1);
    d0 = done_cnt;
    @(posedge clk); @(posedge clk); #1;
    fifo_q.delete(); exp_data.delete();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("midrst no done", 64'(done_cnt), 64'(d0));

    // Fresh command after reset: single-beat bursts
    start_cmd(0, 3, 64'h40, 3, 7);
    wait_done("after rst");
    chk("after rst aw2", qget(aw_log, 2), 64'h50);
    chk("after rst wlast count", 64'(wlast_log.size()), 3);
    chk("after rst data1", qget(wlog, 1), 64'hD007_0000_0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_axi_wr.md
DDR_AXI_WR -- requirements
Module: ddr_axi_wr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXI data and FIFO word width (power of 2, >=8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 29, byte address width.
REQ-003 SHALL have parameter BURST_LEN_WIDTH, default 8, burst length field width (value = beats-1).
REQ-004 SHALL have parameter NUM_BURST_WIDTH, default 8, burst count field width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, as follows:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the following ports (name  direction  width  meaning):
- wr_start  in  1  command strobe; sampled only while wr_ready=1.
- wr_burst_len  in  BURST_LEN_WIDTH  beats per burst minus 1.
- wr_num_burst  in  NUM_BURST_WIDTH  number of bursts.
- wr_start_addr  in  ADDR_WIDTH  byte address of first beat.
- wr_ready  out  1  idle, accepting a command.
- wr_done  out  1  one-cycle completion pulse.
- wr_err  out  1  non-OKAY BRESP seen in the last command.
- wr_fifo_rd_en  out  1  pop the write FIFO (first-word-fall-through).
- wr_fifo_rd_data  in  DATA_WIDTH  FIFO head word, valid while not empty.
- wr_fifo_empty  in  1  FIFO empty.
- m_axi_awaddr  out  ADDR_WIDTH  burst address.
- m_axi_awlen  out  8  burst length (zero-extended or truncated from wr_burst_len).
- m_axi_awsize  out  3  constant log2(DATA_WIDTH/8).
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address accepted.
- m_axi_wdata  out  DATA_WIDTH  equals wr_fifo_rd_data.
- m_axi_wstrb  out  DATA_WIDTH/8  all ones.
- m_axi_wlast  out  1  final beat of the burst.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data accepted.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response accept.

Function
REQ-007 SHALL implement states IDLE, AW, W, B, DONE; wr_ready=1 only in IDLE.
REQ-008 IDLE & wr_start: SHALL latch len/count/addr, clear wr_err; next state AW, or DONE if wr_num_burst=0 (no AXI traffic).
REQ-009 AW: m_axi_awvalid=1 (registered), awaddr/awlen stable until awready handshake; then W.
REQ-010 W: m_axi_wvalid = !wr_fifo_empty; wr_fifo_rd_en = wvalid & wready (pop only on handshake).
REQ-011 W: beat counter resets to 0 per burst, increments per handshake; wlast = (beat == latched len); wlast handshake -> B.
REQ-012 Empty FIFO or wready=0 SHALL stall: counter, data order and address hold; no beat lost or duplicated.
REQ-013 B: m_axi_bready=1; on bvalid, bresp!=2'b00 sets wr_err (sticky until next accepted command).
REQ-014 After B handshake: remaining count decremented; if nonzero, awaddr += (len+1)*DATA_WIDTH/8 (mod 2^ADDR_WIDTH) and go to AW; else DONE.
REQ-015 DONE: wr_done=1 for exactly one cycle, then IDLE; wr_err valid with wr_done.
REQ-016 wr_start outside IDLE SHALL be ignored; 4 KB boundary compliance is the caller's responsibility; AW for the next burst is not issued before B of the current one.

Reset
REQ-017 rst SHALL asynchronously force IDLE; wr_ready=1; wr_done, wr_err, awvalid, wvalid, wlast, bready, wr_fifo_rd_en=0; awaddr, awlen, counters=0.
REQ-018 rst mid-operation SHALL abandon the transaction (no completion pulse); normal operation resumes on the first edge after release.

Verification
REQ-019 len=3, num=2, addr=0x100, 8 words in FIFO, awready/wready/bvalid=1, bresp=0 -> AW at 0x100 then 0x120, awlen=3, wlast on beats 4 and 8, single wr_done, wr_err=0.
REQ-020 FIFO empty for 5 cycles after beat 2 -> wvalid=0 and rd_en=0 for those cycles, beat 3 data correct, wlast still on beat 4.
REQ-021 Random wready deassertion -> wdata sequence equals FIFO order; rd_en count equals wready&wvalid count = 8.
REQ-022 bresp=2'b10 on burst 2 of 2 -> wr_err=1 at wr_done, held until the next wr_start, then cleared.
REQ-023 wr_num_burst=0 -> wr_done one cycle after IDLE exit, no awvalid or wvalid ever asserted.
REQ-024 rst pulsed during W -> all valids 0 immediately, wr_ready=1, no wr_done, and a fresh command then completes correctly.
